// File: rtl/clock_set_controller.sv
// Run/set sequencer for the HH:MM:SS clock: field select, increment with auto-repeat, blink, load.
// Latency: all outputs registered, reflecting the state/shadows after each edge; load one cycle after the final mode_press.
// Backpressure: none; press inputs are single-cycle pulses consumed on the edge they arrive.
module clock_set_controller #(
    parameter int BLINK_HALF    = 12_500_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int TIMEOUT       = 500_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_press,
    input  logic       inc_press,
    input  logic       inc_held,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    output logic       run_enable,
    output logic       load,
    output logic [5:0] load_sec,
    output logic [5:0] load_min,
    output logic [4:0] load_hour,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic [4:0] disp_hour,
    output logic [5:0] blank_mask,
    output logic       edit_active
);

    localparam int MAX_AB  = (BLINK_HALF > REPEAT_DELAY) ? BLINK_HALF : REPEAT_DELAY;
    localparam int MAX_CD  = (REPEAT_PERIOD > TIMEOUT) ? REPEAT_PERIOD : TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BL_LAST  = CW'(BLINK_HALF - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    state_t        state, next_state;
    logic [4:0]    sh_hour, sh_hour_n;
    logic [5:0]    sh_min, sh_min_n;
    logic [5:0]    sh_sec, sh_sec_n;
    logic [CW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_ph, blink_ph_n;
    logic [CW-1:0] idle_cnt, idle_cnt_n;
    logic [CW-1:0] held_cnt, held_cnt_n;
    logic          repeating, repeating_n;

    logic in_set, next_in_set, state_chg;
    logic rep_tick, inc_req, inc_ev, timeout_hit;

    always_comb begin
        in_set      = (state != RUN);
        rep_tick    = in_set && inc_held &&
                      (repeating ? (held_cnt >= PER_LAST) : (held_cnt >= DLY_LAST));
        inc_req     = in_set && (inc_press || rep_tick);
        inc_ev      = inc_req && !mode_press;
        timeout_hit = in_set && !mode_press && !inc_req && (idle_cnt >= TO_LAST);

        next_state = state;
        if (mode_press) begin
            case (state)
                RUN:      next_state = SET_HOUR;
                SET_HOUR: next_state = SET_MIN;
                SET_MIN:  next_state = SET_SEC;
                default:  next_state = RUN;
            endcase
        end else if (timeout_hit) begin
            next_state = RUN;
        end
        next_in_set = (next_state != RUN);
        state_chg   = (next_state != state);

        // Capture clamps corrupt live values so shadows are always in range.
        sh_hour_n = sh_hour;
        sh_min_n  = sh_min;
        sh_sec_n  = sh_sec;
        if (state == RUN && mode_press) begin
            sh_hour_n = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
            sh_min_n  = (cur_min  > 6'd59) ? 6'd0 : cur_min;
            sh_sec_n  = (cur_sec  > 6'd59) ? 6'd0 : cur_sec;
        end else if (inc_ev) begin
            case (state)
                SET_HOUR: sh_hour_n = (sh_hour >= 5'd23) ? 5'd0 : sh_hour + 5'd1;
                SET_MIN:  sh_min_n  = (sh_min  >= 6'd59) ? 6'd0 : sh_min  + 6'd1;
                SET_SEC:  sh_sec_n  = (sh_sec  >= 6'd59) ? 6'd0 : sh_sec  + 6'd1;
                default:  ;
            endcase
        end

        blink_cnt_n = '0;
        blink_ph_n  = 1'b0;
        if (next_in_set && !state_chg && !inc_ev) begin
            if (blink_cnt >= BL_LAST) begin
                blink_ph_n = ~blink_ph;
            end else begin
                blink_cnt_n = blink_cnt + 1'b1;
                blink_ph_n  = blink_ph;
            end
        end

        idle_cnt_n = '0;
        if (next_in_set && !mode_press && !inc_req)
            idle_cnt_n = idle_cnt + 1'b1;

        // First tick after REPEAT_DELAY, then every REPEAT_PERIOD while held.
        held_cnt_n  = '0;
        repeating_n = 1'b0;
        if (in_set && inc_held && !state_chg) begin
            if (rep_tick) begin
                repeating_n = 1'b1;
            end else begin
                held_cnt_n  = held_cnt + 1'b1;
                repeating_n = repeating;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            sh_hour   <= '0;
            sh_min    <= '0;
            sh_sec    <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            idle_cnt  <= '0;
            held_cnt  <= '0;
            repeating <= 1'b0;
        end else begin
            state     <= next_state;
            sh_hour   <= sh_hour_n;
            sh_min    <= sh_min_n;
            sh_sec    <= sh_sec_n;
            blink_cnt <= blink_cnt_n;
            blink_ph  <= blink_ph_n;
            idle_cnt  <= idle_cnt_n;
            held_cnt  <= held_cnt_n;
            repeating <= repeating_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_enable  <= 1'b0;
            edit_active <= 1'b0;
            load        <= 1'b0;
            disp_hour   <= '0;
            disp_min    <= '0;
            disp_sec    <= '0;
            blank_mask  <= '0;
        end else begin
            run_enable  <= !next_in_set;
            edit_active <= next_in_set;
            load        <= (state == SET_SEC) && mode_press;
            disp_hour   <= next_in_set ? sh_hour_n : cur_hour;
            disp_min    <= next_in_set ? sh_min_n  : cur_min;
            disp_sec    <= next_in_set ? sh_sec_n  : cur_sec;
            blank_mask  <= '0;
            if (blink_ph_n) begin
                case (next_state)
                    SET_HOUR: blank_mask <= 6'b110000;
                    SET_MIN:  blank_mask <= 6'b001100;
                    SET_SEC:  blank_mask <= 6'b000011;
                    default:  blank_mask <= 6'b000000;
                endcase
            end
        end
    end

    assign load_hour = sh_hour;
    assign load_min  = sh_min;
    assign load_sec  = sh_sec;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small timing parameters (blink 4, repeat 8/3, timeout 16).
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode_press = 1'b0;
    logic       inc_press = 1'b0;
    logic       inc_held = 1'b0;
    logic [5:0] cur_sec = '0;
    logic [5:0] cur_min = '0;
    logic [4:0] cur_hour = '0;
    logic       run_enable, load, edit_active;
    logic [5:0] load_sec, load_min, disp_sec, disp_min, blank_mask;
    logic [4:0] load_hour, disp_hour;

    int checks = 0;
    int failures = 0;

    clock_set_controller #(
        .BLINK_HALF(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode_press(mode_press), .inc_press(inc_press),
        .inc_held(inc_held), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .run_enable(run_enable), .load(load), .load_sec(load_sec), .load_min(load_min),
        .load_hour(load_hour), .disp_sec(disp_sec), .disp_min(disp_min),
        .disp_hour(disp_hour), .blank_mask(blank_mask), .edit_active(edit_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mode_press = 1'b0;
        inc_press  = 1'b0;
        inc_held   = 1'b0;
        reset_n    = 1'b0;
        #3;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic pulse_mode();
        mode_press = 1'b1;
        step();
        mode_press = 1'b0;
    endtask

    task automatic pulse_inc();
        inc_press = 1'b1;
        step();
        inc_press = 1'b0;
    endtask

    task automatic test_reset();
        cur_hour = 5'd3; cur_min = 6'd4; cur_sec = 6'd5;
        reset_n = 1'b0;
        #2;
        step();
        checks++;
        if ({run_enable, load, edit_active, blank_mask, disp_hour, disp_min, disp_sec,
             load_hour, load_min, load_sec} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got run=%b load=%b edit=%b blank=%b disp=%0d:%0d:%0d exp all zero",
                     run_enable, load, edit_active, blank_mask, disp_hour, disp_min, disp_sec);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (run_enable !== 1'b1 || edit_active !== 1'b0) begin
            failures++;
            $display("FAIL run_after_reset got run=%b edit=%b exp run=1 edit=0", run_enable, edit_active);
        end
        checks++;
        if ({disp_hour, disp_min, disp_sec} !== {5'd3, 6'd4, 6'd5}) begin
            failures++;
            $display("FAIL run_disp got %0d:%0d:%0d exp 3:4:5", disp_hour, disp_min, disp_sec);
        end
    endtask

    task automatic test_mode_cycle();
        int loads;
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        do_reset();
        loads = 0;
        pulse_mode();
        checks++;
        if (run_enable !== 1'b0 || edit_active !== 1'b1 || disp_hour !== 5'd12 || load !== 1'b0) begin
            failures++;
            $display("FAIL enter_set_hour got run=%b edit=%b disp_hour=%0d load=%b exp 0 1 12 0",
                     run_enable, edit_active, disp_hour, load);
        end
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        pulse_mode();
        pulse_mode();
        checks++;
        if (run_enable !== 1'b0 || edit_active !== 1'b1 || load !== 1'b0 || disp_min !== 6'd34) begin
            failures++;
            $display("FAIL in_set_sec got run=%b edit=%b load=%b disp_min=%0d exp 0 1 0 34",
                     run_enable, edit_active, load, disp_min);
        end
        pulse_mode();
        checks++;
        if (load !== 1'b1 || run_enable !== 1'b1 || edit_active !== 1'b0) begin
            failures++;
            $display("FAIL exit_load got load=%b run=%b edit=%b exp 1 1 0", load, run_enable, edit_active);
        end
        checks++;
        if ({load_hour, load_min, load_sec} !== {5'd12, 6'd34, 6'd56}) begin
            failures++;
            $display("FAIL load_value got %0d:%0d:%0d exp 12:34:56", load_hour, load_min, load_sec);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (load === 1'b1) loads++;
        end
        checks++;
        if (loads !== 0 || run_enable !== 1'b1) begin
            failures++;
            $display("FAIL load_single got extra_loads=%0d run=%b exp 0 1", loads, run_enable);
        end
    endtask

    task automatic test_wrap();
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd7;
        do_reset();
        pulse_mode();
        pulse_inc();
        checks++;
        if (disp_hour !== 5'd0 || load_hour !== 5'd0 || load_min !== 6'd59 || load_sec !== 6'd7) begin
            failures++;
            $display("FAIL hour_wrap got disp_hour=%0d load=%0d:%0d:%0d exp 0 0:59:7",
                     disp_hour, load_hour, load_min, load_sec);
        end
        pulse_mode();
        pulse_inc();
        checks++;
        if (disp_min !== 6'd0 || load_hour !== 5'd0 || load_sec !== 6'd7) begin
            failures++;
            $display("FAIL min_wrap got disp_min=%0d hour=%0d sec=%0d exp 0 0 7",
                     disp_min, load_hour, load_sec);
        end
        pulse_mode();
        pulse_inc();
        pulse_inc();
        checks++;
        if (load_sec !== 6'd9 || load_min !== 6'd0) begin
            failures++;
            $display("FAIL sec_inc got sec=%0d min=%0d exp 9 0", load_sec, load_min);
        end
    endtask

    task automatic test_clamp();
        cur_hour = 5'd30; cur_min = 6'd61; cur_sec = 6'd63;
        do_reset();
        pulse_mode();
        checks++;
        if ({load_hour, load_min, load_sec} !== '0 || disp_hour !== 5'd0) begin
            failures++;
            $display("FAIL clamp got %0d:%0d:%0d disp_hour=%0d exp 0:0:0 0",
                     load_hour, load_min, load_sec, disp_hour);
        end
    endtask

    task automatic test_auto_repeat();
        cur_hour = 5'd2; cur_min = 6'd10; cur_sec = 6'd20;
        do_reset();
        pulse_mode();
        pulse_mode();
        inc_held = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 7) begin
                checks++;
                if (disp_min !== 6'd10) begin
                    failures++;
                    $display("FAIL repeat_before_delay got %0d exp 10", disp_min);
                end
            end
            if (k == 8) begin
                checks++;
                if (disp_min !== 6'd11) begin
                    failures++;
                    $display("FAIL repeat_first got %0d exp 11", disp_min);
                end
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (disp_min !== ((k == 10) ? 6'd11 : 6'd12)) begin
                    failures++;
                    $display("FAIL repeat_period k=%0d got %0d exp %0d", k, disp_min, (k == 10) ? 11 : 12);
                end
            end
        end
        checks++;
        if (disp_min !== 6'd15 || load_hour !== 5'd2 || load_sec !== 6'd20) begin
            failures++;
            $display("FAIL repeat_final got min=%0d hour=%0d sec=%0d exp 15 2 20", disp_min, load_hour, load_sec);
        end
        inc_held = 1'b0;
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (disp_min !== 6'd15 || edit_active !== 1'b1) begin
            failures++;
            $display("FAIL repeat_release got min=%0d edit=%b exp 15 1", disp_min, edit_active);
        end
    endtask

    task automatic test_blink();
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        do_reset();
        pulse_mode();
        pulse_mode();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3 || k == 4 || k == 7 || k == 8 || k == 12) begin
                checks++;
                if (blank_mask !== (((k >= 4 && k < 8) || k == 12) ? 6'b001100 : 6'b000000)) begin
                    failures++;
                    $display("FAIL blink k=%0d got %b exp %b", k, blank_mask,
                             ((k >= 4 && k < 8) || k == 12) ? 6'b001100 : 6'b000000);
                end
            end
        end
        pulse_inc();
        checks++;
        if (blank_mask !== 6'b000000 || disp_min !== 6'd3) begin
            failures++;
            $display("FAIL blink_inc got blank=%b min=%0d exp 000000 3", blank_mask, disp_min);
        end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (blank_mask !== 6'b000000) begin
            failures++;
            $display("FAIL blink_restart_early got %b exp 000000", blank_mask);
        end
        step();
        checks++;
        if (blank_mask !== 6'b001100) begin
            failures++;
            $display("FAIL blink_restart got %b exp 001100", blank_mask);
        end
    endtask

    task automatic test_timeout();
        int loads;
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        do_reset();
        loads = 0;
        pulse_mode();
        pulse_mode();
        pulse_mode();
        for (int k = 0; k < 15; k++) begin
            step();
            if (load === 1'b1) loads++;
        end
        checks++;
        if (edit_active !== 1'b1 || run_enable !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got edit=%b run=%b exp 1 0", edit_active, run_enable);
        end
        step();
        if (load === 1'b1) loads++;
        checks++;
        if (edit_active !== 1'b0 || run_enable !== 1'b1 || loads !== 0) begin
            failures++;
            $display("FAIL timeout_abort got edit=%b run=%b loads=%0d exp 0 1 0", edit_active, run_enable, loads);
        end
        checks++;
        if ({load_hour, load_min, load_sec} !== {5'd5, 6'd6, 6'd7}) begin
            failures++;
            $display("FAIL timeout_shadow got %0d:%0d:%0d exp 5:6:7", load_hour, load_min, load_sec);
        end
    endtask

    task automatic test_mode_wins();
        cur_hour = 5'd8; cur_min = 6'd9; cur_sec = 6'd10;
        do_reset();
        pulse_mode();
        mode_press = 1'b1;
        inc_press  = 1'b1;
        step();
        mode_press = 1'b0;
        inc_press  = 1'b0;
        checks++;
        if (load_hour !== 5'd8 || edit_active !== 1'b1) begin
            failures++;
            $display("FAIL mode_wins_hour got hour=%0d edit=%b exp 8 1", load_hour, edit_active);
        end
        pulse_inc();
        checks++;
        if (load_min !== 6'd10 || load_hour !== 5'd8) begin
            failures++;
            $display("FAIL mode_wins_state got min=%0d hour=%0d exp 10 8", load_min, load_hour);
        end
    endtask

    task automatic test_reset_mid_edit();
        int loads;
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        do_reset();
        loads = 0;
        pulse_mode();
        pulse_mode();
        pulse_inc();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({run_enable, load, edit_active, blank_mask, disp_hour, disp_min, disp_sec,
             load_hour, load_min, load_sec} !== '0) begin
            failures++;
            $display("FAIL mid_edit_reset got run=%b edit=%b load=%0d:%0d:%0d exp all zero",
                     run_enable, edit_active, load_hour, load_min, load_sec);
        end
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (load === 1'b1) loads++;
        end
        checks++;
        if (loads !== 0 || run_enable !== 1'b1 || edit_active !== 1'b0 || disp_min !== 6'd2) begin
            failures++;
            $display("FAIL after_mid_reset got loads=%0d run=%b edit=%b disp_min=%0d exp 0 1 0 2",
                     loads, run_enable, edit_active, disp_min);
        end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_wrap();
        test_clamp();
        test_auto_repeat();
        test_blink();
        test_timeout();
        test_mode_wins();
        test_reset_mid_edit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
